// File: rtl/mc_mainfsm.sv
// rtl/mc_mainfsm.sv - multicycle ARM main sequencing FSM (optional MC_STALL_EN memory handshake)
module mc_mainfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
`ifdef MC_STALL_EN
    input  logic       MemReady,
`endif
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    typedef struct packed {
        logic       irwrite;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       aluop;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       branch;
    } ctrl_t;

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;
    logic   mem_ready;
    logic   active;
    logic   unused_funct;

`ifdef MC_STALL_EN
    assign mem_ready = MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    // Funct[4:1] only matter to the ALU decoder, not to sequencing.
    assign unused_funct = ^Funct[4:1];

    // Control word for a state; strobes that need the memory handshake are
    // qualified later, so this table is purely a function of the state.
    function automatic ctrl_t decode_outputs(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite   = 1'b1;
                c.alusrca   = 2'd1;
                c.alusrcb   = 2'd2;
                c.resultsrc = 2'd2;
                c.nextpc    = 1'b1;
            end
            DECODE: begin
                c.alusrca   = 2'd1;
                c.alusrcb   = 2'd2;
                c.resultsrc = 2'd2;
            end
            MEMADR: begin
                c.alusrcb   = 2'd1;
            end
            MEMREAD: begin
                c.adrsrc    = 1'b1;
            end
            MEMWB: begin
                c.resultsrc = 2'd1;
                c.regw      = 1'b1;
            end
            MEMWRITE: begin
                c.adrsrc    = 1'b1;
                c.memw      = 1'b1;
            end
            EXECUTER: begin
                c.aluop     = 1'b1;
            end
            EXECUTEI: begin
                c.alusrcb   = 2'd1;
                c.aluop     = 1'b1;
            end
            ALUWB: begin
                c.regw      = 1'b1;
            end
            BRANCH: begin
                c.alusrcb   = 2'd1;
                c.resultsrc = 2'd2;
                c.branch    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection; memory-facing states wait for the handshake.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // State register with the control word registered alongside it, so the
    // outputs leave a flop rather than the decode table.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= decode_outputs(FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_outputs(state_d);
        end
    end

    // Reset and any corrupted state code silence every control output at once.
    assign active = ~reset & (state_q <= BRANCH);

    // One-shot strobes fire only in the cycle memory completes, so a stalled
    // access still writes exactly once; mux selects are unaffected by stalls.
    assign IRWrite   = active & ctrl_q.irwrite & mem_ready;
    assign NextPC    = active & ctrl_q.nextpc & mem_ready;
    assign MemW      = active & ctrl_q.memw & mem_ready;
    assign RegW      = active & ctrl_q.regw;
    assign Branch    = active & ctrl_q.branch;
    assign ALUOp     = active & ctrl_q.aluop;
    assign AdrSrc    = active & ctrl_q.adrsrc;
    assign ALUSrcA   = {2{active}} & ctrl_q.alusrca;
    assign ALUSrcB   = {2{active}} & ctrl_q.alusrcb;
    assign ResultSrc = {2{active}} & ctrl_q.resultsrc;
    assign State     = state_q;

endmodule

// File: tb/tb_mc_mainfsm.sv
// tb/tb_mc_mainfsm.sv - self-checking bench for mc_mainfsm against an instruction-level model
module tb_mc_mainfsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic [3:0] State;

    int tests = 0;
    int fails = 0;
    int irw_n, memw_n, regw_n, br_n;

`ifdef MC_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    mc_mainfsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
`ifdef MC_STALL_EN
        .MemReady  (MemReady),
`endif
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .State     (State)
    );

    always #5 clk = ~clk;

    // Expected {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,NextPC,RegW,MemW,Branch}
    function automatic logic [12:0] exp_vec(input int s, input bit mr);
        bit g;
        g = STALL ? mr : 1'b1;
        case (s)
            0: return {g, 1'b0, 2'd1, 2'd2, 2'd2, 1'b0, g, 1'b0, 1'b0, 1'b0};
            1: return {1'b0, 1'b0, 2'd1, 2'd2, 2'd2, 5'b0};
            2: return {2'b0, 2'd0, 2'd1, 2'd0, 5'b0};
            3: return {1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 5'b0};
            4: return {2'b0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            5: return {1'b0, 1'b1, 6'b0, 1'b0, 1'b0, 1'b0, g, 1'b0};
            6: return {2'b0, 2'd0, 2'd0, 2'd0, 1'b1, 4'b0};
            7: return {2'b0, 2'd0, 2'd1, 2'd0, 1'b1, 4'b0};
            8: return {2'b0, 6'b0, 1'b0, 1'b0, 1'b1, 2'b0};
            9: return {2'b0, 2'd0, 2'd1, 2'd2, 4'b0, 1'b1};
            default: return 13'd0;
        endcase
    endfunction

    function automatic logic [12:0] act_vec();
        return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch};
    endfunction

    // Called just after a rising edge: drive MemReady, check mid-cycle, advance.
    task automatic step_check(input int exp_state, input bit mr, input string tag);
        logic [12:0] e;
        MemReady = mr;
        @(negedge clk);
        e = exp_vec(exp_state, mr);
        tests++;
        if (State !== 4'(exp_state)) begin
            fails++;
            $display("FAIL %s state: got %0d expected %0d", tag, State, exp_state);
        end
        tests++;
        if (act_vec() !== e) begin
            fails++;
            $display("FAIL %s outputs in state %0d: got %b expected %b", tag, exp_state, act_vec(), e);
        end
        irw_n  += int'(IRWrite);
        memw_n += int'(MemW);
        regw_n += int'(RegW);
        br_n   += int'(Branch);
        @(posedge clk);
        #1;
    endtask

    // Walk one instruction from FETCH back to FETCH; stall counts < 0 are random.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                             input int fs, input int ms, input string tag);
        int seq[$];
        int n;
        bit is_ld, is_st, is_dp, is_br;
        Op = op;
        Funct = funct;
        irw_n = 0; memw_n = 0; regw_n = 0; br_n = 0;
        is_dp = (op == 2'b00);
        is_ld = (op == 2'b01) && funct[0];
        is_st = (op == 2'b01) && !funct[0];
        is_br = (op == 2'b10);
        seq = '{0, 1};
        if (is_dp) begin
            seq.push_back(funct[5] ? 7 : 6);
            seq.push_back(8);
        end
        if (is_ld) seq = '{0, 1, 2, 3, 4};
        if (is_st) seq = '{0, 1, 2, 5};
        if (is_br) seq.push_back(9);
        foreach (seq[i]) begin
            if (seq[i] == 0 || seq[i] == 3 || seq[i] == 5) begin
`ifdef MC_STALL_EN
                n = (seq[i] == 0) ? fs : ms;
                if (n < 0) n = int'($urandom_range(0, 3));
                for (int k = 0; k < n; k++) step_check(seq[i], 1'b0, tag);
`endif
                step_check(seq[i], 1'b1, tag);
            end else begin
                step_check(seq[i], 1'($urandom % 2), tag);
            end
        end
        tests++;
        if (irw_n !== 1) begin
            fails++;
            $display("FAIL %s IRWrite pulses: got %0d expected 1", tag, irw_n);
        end
        tests++;
        if (memw_n !== int'(is_st)) begin
            fails++;
            $display("FAIL %s MemW pulses: got %0d expected %0d", tag, memw_n, int'(is_st));
        end
        tests++;
        if (regw_n !== int'(is_ld || is_dp)) begin
            fails++;
            $display("FAIL %s RegW pulses: got %0d expected %0d", tag, regw_n, int'(is_ld || is_dp));
        end
        tests++;
        if (br_n !== int'(is_br)) begin
            fails++;
            $display("FAIL %s Branch pulses: got %0d expected %0d", tag, br_n, int'(is_br));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        MemReady = 1'b0;
        Op = 2'b11;
        Funct = 6'd0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            tests++;
            if (State !== 4'd0) begin
                fails++;
                $display("FAIL reset state: got %0d expected 0", State);
            end
            tests++;
            if (act_vec() !== 13'd0) begin
                fails++;
                $display("FAIL reset outputs: got %b expected 0", act_vec());
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        step_check(0, 1'b1, "post_reset");
        step_check(1, 1'b1, "post_reset_undef");
    endtask

    task automatic test_reset_in_memwrite();
        Op = 2'b01;
        Funct = 6'b000000;
        step_check(0, 1'b1, "rst_mw");
        step_check(1, 1'b1, "rst_mw");
        step_check(2, 1'b1, "rst_mw");
        reset = 1'b1;
        MemReady = 1'b1;
        @(negedge clk);
        tests++;
        if (State !== 4'd5) begin
            fails++;
            $display("FAIL rst_mw state: got %0d expected 5", State);
        end
        tests++;
        if (MemW !== 1'b0 || act_vec() !== 13'd0) begin
            fails++;
            $display("FAIL rst_mw outputs: got %b expected 0", act_vec());
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        step_check(0, 1'b1, "rst_mw_after");
        step_check(1, 1'b1, "rst_mw_after");
        step_check(2, 1'b1, "rst_mw_after");
        step_check(5, 1'b1, "rst_mw_after");
    endtask

    task automatic test_directed();
        run_instr(2'b00, 6'b000000, 0, 0, "add_reg");
        run_instr(2'b00, 6'b100001, 0, 0, "add_imm");
        run_instr(2'b01, 6'b000001, 0, 0, "ldr");
        run_instr(2'b01, 6'b100000, 0, 0, "str");
        run_instr(2'b10, 6'b011110, 0, 0, "branch");
        run_instr(2'b11, 6'b111111, 0, 0, "undef");
    endtask

`ifdef MC_STALL_EN
    task automatic test_stall();
        run_instr(2'b01, 6'b000000, 3, 3, "stall_str");
        run_instr(2'b01, 6'b000001, 3, 2, "stall_ldr");
    endtask
`endif

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            run_instr(2'($urandom), 6'($urandom), -1, -1, "random");
        end
    endtask

    initial begin
        reset = 1'b1;
        MemReady = 1'b1;
        Op = 2'b00;
        Funct = 6'd0;
        test_reset();
        test_directed();
        test_reset_in_memwrite();
`ifdef MC_STALL_EN
        test_stall();
`endif
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
